// File: rtl/spi_mm_pkg.sv
// Shared types and constants for the SPI memory master: FSM states,
// frame command codes and the frame length.
package spi_mm_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      SHIFT,
      TURN,
      CAPTURE,
      GAP
   } state_t;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

   localparam int FRAME_LEN = 10;

endpackage

// File: rtl/spi_mm_shifter.sv
// Serial datapath for the SPI memory master: TX frame shift register,
// RX capture shift register and the shared bit/cycle counter.
module spi_mm_shifter
   import spi_mm_pkg::*;
#(
   parameter int ADDR_SIZE = 8,
   parameter int CNT_W     = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load,
   input  logic [FRAME_LEN-1:0] frame,
   input  logic                 shift_en,
   input  logic                 cap_en,
   input  logic                 cnt_clr,
   input  logic                 miso,
   output logic                 tx_bit,
   output logic [ADDR_SIZE-1:0] rx_data,
   output logic [CNT_W-1:0]     cnt
);

   logic [FRAME_LEN-1:0] tx_reg;
   logic [ADDR_SIZE-1:0] rx_reg;
   logic [ADDR_SIZE-1:0] rx_next;
   logic [CNT_W-1:0]     cnt_reg;

   // MSB-first capture: each new sample enters at bit 0 and older bits move up.
   assign rx_next[0] = miso;
   generate
      for (genvar gi = 1; gi < ADDR_SIZE; gi++) begin : g_rx_shift
         assign rx_next[gi] = rx_reg[gi-1];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_reg  <= '0;
         rx_reg  <= '0;
         cnt_reg <= '0;
      end else begin
         if (load)
            tx_reg <= frame;
         else if (shift_en)
            tx_reg <= {tx_reg[FRAME_LEN-2:0], 1'b0};
         if (cap_en)
            rx_reg <= rx_next;
         if (cnt_clr)
            cnt_reg <= '0;
         else
            cnt_reg <= cnt_reg + CNT_W'(1);
      end
   end

   assign tx_bit  = tx_reg[FRAME_LEN-1];
   assign rx_data = rx_reg;
   assign cnt     = cnt_reg;

endmodule

// File: rtl/spi_mem_master.sv
// Host-request to SPI-frame memory master (write: addr+data frames, read: addr+data
// frames then capture). Optional read-address cache enabled by SPI_MM_RDADDR_CACHE_EN.
module spi_mem_master
   import spi_mm_pkg::*;
#(
   parameter int ADDR_SIZE  = 8,
   parameter int TURNAROUND = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_wr,
   input  logic [ADDR_SIZE-1:0] req_addr,
   input  logic [ADDR_SIZE-1:0] req_wdata,
   output logic                 resp_valid,
   output logic [ADDR_SIZE-1:0] resp_rdata,
   output logic                 busy,
   output logic                 SS_n,
   output logic                 MOSI,
   input  logic                 MISO
);

   localparam int CNT_W = $clog2(FRAME_LEN + TURNAROUND + ADDR_SIZE + 1);
   localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(FRAME_LEN - 1);
   localparam logic [CNT_W-1:0] TURN_LAST  = CNT_W'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);
   localparam logic [CNT_W-1:0] CAP_LAST   = CNT_W'(ADDR_SIZE - 1);

   state_t                state_reg, state_next;
   logic                  data_frame_reg, data_frame_next;
   logic                  wr_reg;
   logic [ADDR_SIZE-1:0]  addr_reg;
   logic [ADDR_SIZE-1:0]  wdata_reg;
   logic [ADDR_SIZE-1:0]  rdata_reg;

   logic                  accept;
   logic                  cache_hit;
   logic                  load, shift_en, cap_en, cnt_clr;
   logic                  rd_done;
   logic [FRAME_LEN-1:0]  frame;
   logic                  tx_bit;
   logic [ADDR_SIZE-1:0]  rx_data;
   logic [CNT_W-1:0]      cnt;

   assign accept = req_valid && (state_reg == IDLE);

`ifdef SPI_MM_RDADDR_CACHE_EN
   logic                  cache_valid_reg;
   logic [ADDR_SIZE-1:0]  cache_addr_reg;

   // The slave keeps its read address across writes, so only reset drops the entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cache_valid_reg <= 1'b0;
         cache_addr_reg  <= '0;
      end else if (accept && !req_wr) begin
         cache_valid_reg <= 1'b1;
         cache_addr_reg  <= req_addr;
      end
   end

   assign cache_hit = !req_wr && cache_valid_reg && (cache_addr_reg == req_addr);
`else
   assign cache_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         data_frame_reg <= 1'b0;
         wr_reg         <= 1'b0;
         addr_reg       <= '0;
         wdata_reg      <= '0;
         rdata_reg      <= '0;
      end else begin
         state_reg      <= state_next;
         data_frame_reg <= data_frame_next;
         if (accept) begin
            wr_reg    <= req_wr;
            addr_reg  <= req_addr;
            wdata_reg <= req_wdata;
         end
         if (rd_done)
            rdata_reg <= rx_data;
      end
   end

   always_comb begin
      frame = {CMD_WR_ADDR, addr_reg};
      if (!data_frame_reg)
         frame = {(wr_reg ? CMD_WR_ADDR : CMD_RD_ADDR), addr_reg};
      else if (wr_reg)
         frame = {CMD_WR_DATA, wdata_reg};
      else
         frame = {CMD_RD_DATA, {ADDR_SIZE{1'b0}}};
   end

   // Counter is held clear in every state that does not time itself.
   always_comb begin
      state_next      = state_reg;
      data_frame_next = data_frame_reg;
      load            = 1'b0;
      shift_en        = 1'b0;
      cap_en          = 1'b0;
      cnt_clr         = 1'b1;
      case (state_reg)
         IDLE: begin
            if (req_valid) begin
               state_next      = START;
               data_frame_next = cache_hit;
            end
         end
         START: begin
            load       = 1'b1;
            state_next = SHIFT;
         end
         SHIFT: begin
            shift_en = 1'b1;
            cnt_clr  = 1'b0;
            if (cnt == SHIFT_LAST) begin
               cnt_clr = 1'b1;
               if (data_frame_reg && !wr_reg)
                  state_next = (TURNAROUND > 0) ? TURN : CAPTURE;
               else
                  state_next = GAP;
            end
         end
         TURN: begin
            cnt_clr = 1'b0;
            if (cnt == TURN_LAST) begin
               cnt_clr    = 1'b1;
               state_next = CAPTURE;
            end
         end
         CAPTURE: begin
            cap_en  = 1'b1;
            cnt_clr = 1'b0;
            if (cnt == CAP_LAST) begin
               cnt_clr    = 1'b1;
               state_next = GAP;
            end
         end
         GAP: begin
            if (data_frame_reg) begin
               state_next = IDLE;
            end else begin
               state_next      = START;
               data_frame_next = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   spi_mm_shifter #(
      .ADDR_SIZE (ADDR_SIZE),
      .CNT_W     (CNT_W)
   ) u_shifter (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .frame    (frame),
      .shift_en (shift_en),
      .cap_en   (cap_en),
      .cnt_clr  (cnt_clr),
      .miso     (MISO),
      .tx_bit   (tx_bit),
      .rx_data  (rx_data),
      .cnt      (cnt)
   );

   // The final GAP of a read shows the freshly captured byte; rdata_reg holds it afterwards.
   assign rd_done    = (state_reg == GAP) && data_frame_reg && !wr_reg;
   assign resp_rdata = rd_done ? rx_data : rdata_reg;

   assign req_ready  = (state_reg == IDLE);
   assign busy       = !req_ready;
   assign resp_valid = (state_reg == GAP) && data_frame_reg;
   assign SS_n       = !((state_reg == START) || (state_reg == SHIFT) ||
                         (state_reg == TURN)  || (state_reg == CAPTURE));
   assign MOSI       = (state_reg == SHIFT) && tx_bit;

endmodule

// File: tb/tb_spi_mem_master.sv
// Bench for spi_mem_master: SPI slave with RAM, directed table, reset abort,
// back-to-back and random transactions against a transaction-level model.
module tb_spi_mem_master;

   localparam int TA = 1;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req_valid, req_ready, req_wr;
   logic [7:0] req_addr, req_wdata;
   logic       resp_valid, busy, ss_n, mosi, miso;
   logic [7:0] resp_rdata;

   spi_mem_master #(.ADDR_SIZE(8), .TURNAROUND(TA)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_wr     (req_wr),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .busy       (busy),
      .SS_n       (ss_n),
      .MOSI       (mosi),
      .MISO       (miso)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // transaction-level model
   bit [7:0] ref_mem [256];
   bit       cache_v;
   bit [7:0] cache_a;
   bit [7:0] last_rdata;

   // SPI slave with its own RAM
   bit [7:0] slv_ram [256];
   bit [7:0] slv_wa, slv_ra, slv_rd;
   int       slv_k = 0;
   bit [9:0] slv_sh, slv_f;
   bit [9:0] frames_q [$];

   typedef struct {
      bit       wr;
      bit [7:0] addr;
      bit [7:0] wdata;
      bit [7:0] exp_rdata;
   } vec_t;

   vec_t tbl [12];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      miso <= 1'($urandom);
      if (ss_n) begin
         slv_k <= 0;
      end else begin
         slv_k <= slv_k + 1;
         if (slv_k >= 1 && slv_k <= 10) begin
            slv_f = {slv_sh[8:0], mosi};
            slv_sh <= slv_f;
            if (slv_k == 10) begin
               frames_q.push_back(slv_f);
               case (slv_f[9:8])
                  2'd0: slv_wa <= slv_f[7:0];
                  2'd1: slv_ram[slv_wa] <= slv_f[7:0];
                  2'd2: slv_ra <= slv_f[7:0];
                  default: slv_rd <= slv_ram[slv_ra];
               endcase
            end
         end
         if (slv_k >= 11 + TA && slv_k <= 18 + TA)
            miso <= slv_rd[7 - (slv_k - 11 - TA)];
      end
   end

   // Called at a negedge with the DUT idle or finishing; returns at a negedge.
   task automatic run_txn(input bit wr, input bit [7:0] addr, input bit [7:0] wdata,
                          input bit [7:0] exp_rd, input string tag);
      bit       hit;
      int       exp_cyc, w, n, rdy_bad, busy_bad;
      bit       got;
      bit [9:0] exp_f [$];
      hit = 1'b0;
`ifdef SPI_MM_RDADDR_CACHE_EN
      hit = !wr && cache_v && (cache_a == addr);
`endif
      if (wr) begin
         exp_f.push_back({2'b00, addr});
         exp_f.push_back({2'b01, wdata});
         exp_cyc = 24;
         ref_mem[addr] = wdata;
      end else begin
         if (!hit) exp_f.push_back({2'b10, addr});
         exp_f.push_back({2'b11, 8'h00});
         exp_cyc = hit ? 20 + TA : 32 + TA;
         cache_v = 1'b1;
         cache_a = addr;
      end
      frames_q.delete();
      w = 0;
      while (!req_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (!req_ready) begin
         chk({tag, "_ready_timeout"}, 0, 1);
         return;
      end
      req_valid = 1'b1;
      req_wr    = wr;
      req_addr  = addr;
      req_wdata = wdata;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_wr    = 1'($urandom);
      req_addr  = 8'($urandom);
      req_wdata = 8'($urandom);
      n = 0; got = 1'b0; rdy_bad = 0; busy_bad = 0;
      while (!got && n < 100) begin
         @(negedge clk);
         n++;
         if (req_ready) rdy_bad++;
         if (busy == req_ready) busy_bad++;
         if (resp_valid) got = 1'b1;
      end
      $display("txn %s wr=%0d addr=%02h wdata=%02h rdata=%02h cycles=%0d",
               tag, wr, addr, wdata, resp_rdata, n);
      chk({tag, "_latency"}, got ? n : -1, exp_cyc);
      chk({tag, "_ready_low"}, rdy_bad, 0);
      chk({tag, "_busy"}, busy_bad, 0);
      if (!wr) begin
         chk({tag, "_rdata"}, int'(resp_rdata), int'(exp_rd));
         last_rdata = exp_rd;
      end else begin
         chk({tag, "_rdata_hold"}, int'(resp_rdata), int'(last_rdata));
      end
      chk({tag, "_nframes"}, frames_q.size(), exp_f.size());
      for (int i = 0; i < exp_f.size(); i++)
         if (i < frames_q.size())
            chk({tag, "_frame"}, int'(frames_q[i]), int'(exp_f[i]));
      @(negedge clk);
      chk({tag, "_pulse_end"}, int'(resp_valid), 0);
      chk({tag, "_ss_idle"}, int'(ss_n), 1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int       acc, resp_n, rdy_n, hi, min_gap, gaps, cyc, busy_bad, n;
      bit       meas, took, wr;
      bit [7:0] addr, wdata;

      tbl[0]  = '{1'b1, 8'h04, 8'hA5, 8'h00};
      tbl[1]  = '{1'b0, 8'h04, 8'h00, 8'hA5};
      tbl[2]  = '{1'b1, 8'h10, 8'h3C, 8'h00};
      tbl[3]  = '{1'b0, 8'h10, 8'h00, 8'h3C};
      tbl[4]  = '{1'b0, 8'h10, 8'h00, 8'h3C};
      tbl[5]  = '{1'b1, 8'h10, 8'hC3, 8'h00};
      tbl[6]  = '{1'b0, 8'h10, 8'h00, 8'hC3};
      tbl[7]  = '{1'b1, 8'hFF, 8'h00, 8'h00};
      tbl[8]  = '{1'b0, 8'hFF, 8'h00, 8'h00};
      tbl[9]  = '{1'b1, 8'h00, 8'hFF, 8'h00};
      tbl[10] = '{1'b0, 8'h00, 8'h00, 8'hFF};
      tbl[11] = '{1'b0, 8'h04, 8'h00, 8'hA5};

      for (int i = 0; i < 256; i++) begin
         ref_mem[i] = 8'h00;
         slv_ram[i] = 8'h00;
      end
      cache_v = 1'b0; cache_a = 8'h00; last_rdata = 8'h00;
      rst_n = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
      #2 rst_n = 1'b0;
      #2;
      chk("reset_ss_n", int'(ss_n), 1);
      chk("reset_mosi", int'(mosi), 0);
      chk("reset_resp_valid", int'(resp_valid), 0);
      chk("reset_rdata", int'(resp_rdata), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_ready", int'(req_ready), 1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++)
         run_txn(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rdata, $sformatf("tbl%0d", i));
      chk("ram4_after_write", int'(slv_ram[4]), 8'hA5);

      // abort a write to 8'h24 during the 5th MOSI bit (frame bit 5 = addr bit 5 = 1)
      req_valid = 1'b1; req_wr = 1'b1; req_addr = 8'h24; req_wdata = 8'h5A;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (6) @(negedge clk);
      chk("abort_in_shift_ss", int'(ss_n), 0);
      chk("abort_in_shift_mosi", int'(mosi), 1);
      rst_n = 1'b0;
      #1;
      chk("abort_ss_n", int'(ss_n), 1);
      chk("abort_mosi", int'(mosi), 0);
      chk("abort_ready", int'(req_ready), 1);
      chk("abort_busy", int'(busy), 0);
      chk("abort_rdata", int'(resp_rdata), 0);
      cache_v = 1'b0; last_rdata = 8'h00;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      repeat (30) begin
         @(negedge clk);
         if (resp_valid) n++;
      end
      $display("txn abort wr=1 addr=24 wdata=5a resp_pulses=%0d", n);
      chk("abort_no_resp", n, 0);
      chk("abort_ram24", int'(slv_ram[8'h24]), int'(ref_mem[8'h24]));
      run_txn(1'b0, 8'h04, 8'h00, 8'hA5, "rst_read");

      // req_valid held high across three writes
      acc = 0; resp_n = 0; rdy_n = 0; meas = 1'b0; hi = 0; min_gap = 99; gaps = 0;
      cyc = 0; busy_bad = 0;
      req_valid = 1'b1; req_wr = 1'b1; req_addr = 8'h30; req_wdata = 8'($urandom);
      while (resp_n < 3 && cyc < 150) begin
         if (busy == req_ready) busy_bad++;
         if (meas) begin
            if (ss_n) hi++;
            else begin
               meas = 1'b0;
               gaps++;
               if (hi < min_gap) min_gap = hi;
            end
         end
         if (resp_valid) begin
            resp_n++;
            meas = 1'b1;
            hi = 1;
         end
         took = req_ready && req_valid;
         if (req_ready) rdy_n++;
         if (took) begin
            acc++;
            ref_mem[req_addr] = req_wdata;
         end
         @(posedge clk);
         #1;
         if (took) begin
            if (acc == 3) req_valid = 1'b0;
            else begin
               req_addr  = req_addr + 8'h01;
               req_wdata = 8'($urandom);
            end
         end
         @(negedge clk);
         cyc++;
      end
      $display("txn b2b accepts=%0d resps=%0d min_gap=%0d cycles=%0d", acc, resp_n, min_gap, cyc);
      chk("b2b_accepts", acc, 3);
      chk("b2b_resps", resp_n, 3);
      chk("b2b_ready_cycles", rdy_n, 3);
      chk("b2b_busy", busy_bad, 0);
      chk("b2b_gaps", gaps, 2);
      chk("b2b_min_gap_ge2", int'(min_gap >= 2), 1);
      for (int a = 8'h30; a < 8'h33; a++)
         chk("b2b_ram", int'(slv_ram[a]), int'(ref_mem[a]));

      for (int i = 0; i < 40; i++) begin
         wr    = 1'($urandom_range(0, 1));
         addr  = 8'h40 + 8'($urandom_range(0, 3));
         wdata = 8'($urandom);
         run_txn(wr, addr, wdata, ref_mem[addr], $sformatf("rnd%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spi_mem_master.md
SPI_MEM_MASTER -- requirements
Module: spi_mem_master

Interface
REQ-001 Parameter ADDR_SIZE, default 8, meaning width of address and data byte carried in each SPI frame.
REQ-002 Parameter TURNAROUND, default 1, meaning idle cycles between the end of the read-data frame and the first MISO sample.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, named as follows.
REQ-004 clk  input  1  sole clock, all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  1  host request present.
REQ-007 req_ready  output  1  block can accept a request this cycle.
REQ-008 req_wr  input  1  1 = memory write, 0 = memory read.
REQ-009 req_addr  input  ADDR_SIZE  target memory address.
REQ-010 req_wdata  input  ADDR_SIZE  write data; ignored on reads.
REQ-011 resp_valid  output  1  one-cycle pulse marking transaction completion.
REQ-012 resp_rdata  output  ADDR_SIZE  read data, valid while resp_valid is high and held until the next read completes.
REQ-013 busy  output  1  transaction in progress.
REQ-014 SS_n  output  1  slave select to the SPI slave, active low.
REQ-015 MOSI  output  1  serial data to the slave.
REQ-016 MISO  input  1  serial data from the slave.

Function
REQ-017 The block SHALL accept a request on a rising edge where req_valid and req_ready are both 1, and SHALL register req_wr, req_addr and req_wdata at that edge.
REQ-018 req_ready SHALL equal (state == IDLE); while busy, req_valid is ignored and no request is queued.
REQ-019 The frame format SHALL be 10 bits, MSB first: 2-bit command then an ADDR_SIZE payload; command 00 = write address, 01 = write data, 10 = read address, 11 = read data.
REQ-020 The FSM SHALL have the states IDLE, START, SHIFT, TURN, CAPTURE, GAP.
REQ-021 Transitions: IDLE->START on accept; START->SHIFT after 1 cycle; SHIFT->GAP after 10 cycles, or SHIFT->TURN on a read-data frame; TURN->CAPTURE after TURNAROUND cycles; CAPTURE->GAP after 8 cycles; GAP->START if a frame remains, otherwise GAP->IDLE.
REQ-022 SS_n SHALL be 0 in the START, SHIFT, TURN and CAPTURE states, and 1 in the IDLE and GAP states.
REQ-023 MOSI SHALL present one frame bit per SHIFT cycle (bit 9 first) and SHALL be 0 in every other state.
REQ-024 A write SHALL issue the frames {00,addr} and then {01,wdata}, for exactly 24 cycles from accept to the end of the last GAP.
REQ-025 A read SHALL issue the frames {10,addr} and then {11,8'h00}, followed by TURN and CAPTURE, for exactly 32+TURNAROUND cycles.
REQ-026 CAPTURE SHALL sample MISO on each rising edge, MSB first, into a shift register; resp_rdata SHALL update on the final sample.
REQ-027 resp_valid SHALL be high for exactly the final GAP cycle of each transaction; busy = !req_ready.
REQ-028 Back-to-back: a request presented during the final GAP cycle SHALL be accepted on the first IDLE cycle; SS_n SHALL be high for at least 2 cycles between transactions.

Reset
REQ-029 On rst_n=0 the block SHALL asynchronously force state=IDLE, SS_n=1, MOSI=0, resp_valid=0, resp_rdata=0, busy=0, req_ready=1, and clear all counters and the cache.
REQ-030 Reset mid-transaction SHALL abort the transaction with no resp_valid pulse; the first request after reset SHALL start from the first frame.

Configuration
REQ-031 Macro SPI_MM_RDADDR_CACHE_EN: when defined, the block SHALL keep the last read address plus a valid bit, and a read to an equal address SHALL skip the {10,addr} frame (one frame, 20+TURNAROUND cycles).
REQ-032 With SPI_MM_RDADDR_CACHE_EN defined, the cache SHALL be invalidated only by reset; writes SHALL NOT invalidate it, because the slave holds separate read and write address registers.
REQ-033 Without SPI_MM_RDADDR_CACHE_EN, every read SHALL issue both frames and no cache storage SHALL exist.

Structure
REQ-034 Package spi_mm_pkg SHALL hold the state enum, the command constants (CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11) and FRAME_LEN=10.
REQ-035 A sub-module spi_mm_shifter SHALL contain the 10-bit TX shift register, the 8-bit RX shift register and the bit counter; the FSM SHALL stay in the top module.

Verification
REQ-036 Write addr 8'h04, data 8'hA5 to the slave-plus-RAM wrapper -> MOSI streams 00_00000100 then 01_10100101; resp_valid at cycle 24; RAM[4]==8'hA5.
REQ-037 Read addr 8'h04 after REQ-036 -> frames 10_00000100 and 11_00000000; resp_rdata==8'hA5 with a single resp_valid pulse.
REQ-038 Assert req_valid continuously for 3 write requests -> exactly 3 accepts, req_ready low throughout each transaction, SS_n high for at least 2 cycles between transactions.
REQ-039 Assert rst_n=0 in SHIFT during the 5th bit -> SS_n=1 and MOSI=0 immediately, no resp_valid; the next read of 8'h04 still returns 8'hA5.
REQ-040 With SPI_MM_RDADDR_CACHE_EN, two reads of 8'h10 -> the second read has no 10-frame and completes in 21 cycles; with the macro undefined it completes in 33 cycles.
